// File: rtl/heap_level_store.sv
// -----------------------------------------------------------------------------
// heap_level_store
//
// Count/address/valid storage for one level of the sorted max-heap. It holds
// NUM_CNT = 2**(CURRENT_LEVEL-1) entries.
//
// Features:
//   - Two write ports (A and B), so a sift swap can update parent and child in
//     a single cycle.
//   - A saturating in-place count increment.
//   - A registered sibling-pair read port that feeds the sift comparator.
//   - Collision and range error pulses.
//
// Optional feature (macro HEAP_LEVEL_STORE_RD_BYPASS_EN):
//   - Defined:   a read of an entry that is updated in the same cycle returns
//                the post-update value.
//   - Undefined: the read returns the pre-update register value.
//   Store behaviour is identical either way.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   clear               synchronous flush of all entries
//   wr_a_* / wr_b_*     write ports; A has priority over B
//   inc_en, inc_index   saturating +1 on one entry's count
//   rd_en, rd_pair      pair read request; pair k selects entries 2k and 2k+1
//   rd_valid, rd_*0/1   registered pair read result
//   stored_cnt/addr     live register arrays, packed with entry i at slice i
//   entry_valid         per-entry occupied bit
//   err_collide         pulse: an operation was dropped because it collided
//   err_range           pulse: an enabled index was out of range
//
// Handshake: every strobe (wr_a_en, wr_b_en, inc_en, rd_en) is accepted in
// the cycle it is high. There is no backpressure. rd_valid is high for exactly
// one cycle, one cycle after rd_en. rd_* data holds its value while rd_valid
// is low.
// -----------------------------------------------------------------------------
module heap_level_store #(
    parameter int CNT_SIZE      = 20,
    parameter int ADDR_SIZE     = 28,
    parameter int TOTAL_LEVEL   = 6,
    parameter int CURRENT_LEVEL = 3,
    localparam int NUM_CNT      = 2 ** (CURRENT_LEVEL - 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          wr_a_en,
    input  logic [TOTAL_LEVEL-1:0]        wr_a_index,
    input  logic [CNT_SIZE-1:0]           wr_a_cnt,
    input  logic [ADDR_SIZE-1:0]          wr_a_addr,
    input  logic                          wr_b_en,
    input  logic [TOTAL_LEVEL-1:0]        wr_b_index,
    input  logic [CNT_SIZE-1:0]           wr_b_cnt,
    input  logic [ADDR_SIZE-1:0]          wr_b_addr,
    input  logic                          inc_en,
    input  logic [TOTAL_LEVEL-1:0]        inc_index,
    input  logic                          rd_en,
    input  logic [TOTAL_LEVEL-1:0]        rd_pair,
    output logic                          rd_valid,
    output logic [CNT_SIZE-1:0]           rd_cnt0,
    output logic [CNT_SIZE-1:0]           rd_cnt1,
    output logic [ADDR_SIZE-1:0]          rd_addr0,
    output logic [ADDR_SIZE-1:0]          rd_addr1,
    output logic                          rd_vld0,
    output logic                          rd_vld1,
    output logic [CNT_SIZE*NUM_CNT-1:0]   stored_cnt,
    output logic [ADDR_SIZE*NUM_CNT-1:0]  stored_addr,
    output logic [NUM_CNT-1:0]            entry_valid,
    output logic                          err_collide,
    output logic                          err_range
);

    localparam int NUM_PAIR = (NUM_CNT + 1) / 2;
    // NUM_CNT <= 2**(TOTAL_LEVEL-1), so both bounds fit in an index word.
    localparam logic [TOTAL_LEVEL-1:0] NUM_CNT_IDX  = TOTAL_LEVEL'(NUM_CNT);
    localparam logic [TOTAL_LEVEL-1:0] NUM_PAIR_IDX = TOTAL_LEVEL'(NUM_PAIR);
    localparam logic [CNT_SIZE-1:0]    CNT_MAX      = {CNT_SIZE{1'b1}};

    logic [CNT_SIZE-1:0]  cnt_q   [NUM_CNT];
    logic [ADDR_SIZE-1:0] addr_q  [NUM_CNT];
    logic [NUM_CNT-1:0]   vld_q;

    // Post-update values before clear is applied.
    logic [CNT_SIZE-1:0]  cnt_nxt  [NUM_CNT];
    logic [ADDR_SIZE-1:0] addr_nxt [NUM_CNT];
    logic [NUM_CNT-1:0]   vld_nxt;

    logic a_ok, b_ok, inc_ok, rd_in;
    logic b_drop, inc_drop;
    logic range_hit, collide_hit;

    logic [CNT_SIZE-1:0]  sel_cnt0, sel_cnt1;
    logic [ADDR_SIZE-1:0] sel_addr0, sel_addr1;
    logic                 sel_vld0, sel_vld1;

    // ---------------------------------------------------------------- decode
    always_comb begin
        a_ok   = wr_a_en && (wr_a_index < NUM_CNT_IDX);
        b_ok   = wr_b_en && (wr_b_index < NUM_CNT_IDX);
        inc_ok = inc_en  && (inc_index  < NUM_CNT_IDX);
        rd_in  = rd_pair < NUM_PAIR_IDX;

        // B loses to A on the same entry.
        b_drop = a_ok && b_ok && (wr_a_index == wr_b_index);

        // An increment loses to any in-range write of the same entry. This
        // includes a B write that is itself dropped.
        inc_drop = inc_ok &&
                   ((a_ok && (inc_index == wr_a_index)) ||
                    (b_ok && (inc_index == wr_b_index)));

        range_hit = (wr_a_en && !(wr_a_index < NUM_CNT_IDX)) ||
                    (wr_b_en && !(wr_b_index < NUM_CNT_IDX)) ||
                    (inc_en  && !(inc_index  < NUM_CNT_IDX)) ||
                    (rd_en   && !rd_in);
        collide_hit = b_drop || inc_drop;
    end

    // ------------------------------------------------------ per-entry update
    always_comb begin
        vld_nxt = vld_q;
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_nxt[i]  = cnt_q[i];
            addr_nxt[i] = addr_q[i];
            if (a_ok && (wr_a_index == TOTAL_LEVEL'(i))) begin
                cnt_nxt[i]  = wr_a_cnt;
                addr_nxt[i] = wr_a_addr;
                vld_nxt[i]  = 1'b1;
            end else if (b_ok && !b_drop && (wr_b_index == TOTAL_LEVEL'(i))) begin
                cnt_nxt[i]  = wr_b_cnt;
                addr_nxt[i] = wr_b_addr;
                vld_nxt[i]  = 1'b1;
            end else if (inc_ok && !inc_drop && (inc_index == TOTAL_LEVEL'(i))) begin
                // Valid bit is left alone; an invalid entry still counts.
                cnt_nxt[i] = (cnt_q[i] == CNT_MAX) ? cnt_q[i]
                                                   : cnt_q[i] + CNT_SIZE'(1);
            end
        end
    end

    // ------------------------------------------------------ pair read select
    // An out-of-range pair matches no entry, so it reads as zeros. For
    // NUM_CNT == 1, slot 1 has no entry and stays zero.
    always_comb begin
        sel_cnt0  = '0;
        sel_cnt1  = '0;
        sel_addr0 = '0;
        sel_addr1 = '0;
        sel_vld0  = 1'b0;
        sel_vld1  = 1'b0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (TOTAL_LEVEL'(i / 2) == rd_pair) begin
`ifdef HEAP_LEVEL_STORE_RD_BYPASS_EN
                if ((i % 2) == 0) begin
                    sel_cnt0  = cnt_nxt[i];
                    sel_addr0 = addr_nxt[i];
                    sel_vld0  = vld_nxt[i];
                end else begin
                    sel_cnt1  = cnt_nxt[i];
                    sel_addr1 = addr_nxt[i];
                    sel_vld1  = vld_nxt[i];
                end
`else
                if ((i % 2) == 0) begin
                    sel_cnt0  = cnt_q[i];
                    sel_addr0 = addr_q[i];
                    sel_vld0  = vld_q[i];
                end else begin
                    sel_cnt1  = cnt_q[i];
                    sel_addr1 = addr_q[i];
                    sel_vld1  = vld_q[i];
                end
`endif
            end
        end
    end

    // --------------------------------------------------------------- storage
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i]  <= '0;
                addr_q[i] <= '0;
            end
        end else if (clear) begin
            vld_q <= '0;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i]  <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_nxt;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i]  <= cnt_nxt[i];
                addr_q[i] <= addr_nxt[i];
            end
        end
    end

    // ------------------------------------------------- read port and errors
    // clear does not gate the read; it returns the data present before the
    // flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid    <= 1'b0;
            rd_cnt0     <= '0;
            rd_cnt1     <= '0;
            rd_addr0    <= '0;
            rd_addr1    <= '0;
            rd_vld0     <= 1'b0;
            rd_vld1     <= 1'b0;
            err_collide <= 1'b0;
            err_range   <= 1'b0;
        end else begin
            rd_valid    <= rd_en;
            err_collide <= collide_hit;
            err_range   <= range_hit;
            if (rd_en) begin
                rd_cnt0  <= sel_cnt0;
                rd_cnt1  <= sel_cnt1;
                rd_addr0 <= sel_addr0;
                rd_addr1 <= sel_addr1;
                rd_vld0  <= sel_vld0;
                rd_vld1  <= sel_vld1;
            end
        end
    end

    // ---------------------------------------------------------- live outputs
    for (genvar g = 0; g < NUM_CNT; g++) begin : g_pack
        assign stored_cnt[g*CNT_SIZE +: CNT_SIZE]    = cnt_q[g];
        assign stored_addr[g*ADDR_SIZE +: ADDR_SIZE] = addr_q[g];
    end
    assign entry_valid = vld_q;

endmodule
